// File: rtl/frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// frame_sequencer_pkg
// Shared constants for the datapath instruction interface: opcodes, word and
// field widths, field positions inside the instruction word, the sequencer
// state/mode enums and a helper that packs an instruction word.
// ---------------------------------------------------------------------------
package frame_sequencer_pkg;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int OPCODE_WIDTH      = 4;
  localparam int X_COORD_WIDTH     = 8;
  localparam int Y_COORD_WIDTH     = 7;
  localparam int COLOUR_WIDTH      = 3;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW    = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = 4'h4;

  // Field positions inside the instruction word; bits above WE_BIT stay 0.
  localparam int OPCODE_LSB = 0;
  localparam int X_LSB      = 4;
  localparam int Y_LSB      = 12;
  localparam int COLOUR_LSB = 19;
  localparam int WE_BIT     = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_WAIT
  } seq_state_t;

  typedef enum logic {
    MODE_CLEAR,
    MODE_REFRESH
  } seq_mode_t;

  function automatic logic [INSTRUCTION_WIDTH-1:0] pack_instruction(
    input logic [OPCODE_WIDTH-1:0]  opcode,
    input logic [X_COORD_WIDTH-1:0] x,
    input logic [Y_COORD_WIDTH-1:0] y,
    input logic [COLOUR_WIDTH-1:0]  colour,
    input logic                     we
  );
    logic [INSTRUCTION_WIDTH-1:0] w;
    w = '0;
    w[OPCODE_LSB +: OPCODE_WIDTH]  = opcode;
    w[X_LSB +: X_COORD_WIDTH]      = x;
    w[Y_LSB +: Y_COORD_WIDTH]      = y;
    w[COLOUR_LSB +: COLOUR_WIDTH]  = colour;
    w[WE_BIT]                      = we;
    return w;
  endfunction

endpackage

// File: rtl/frame_sequencer_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Raster-order x/y pixel counter (x inner, y outer). Holds at the last pixel.
// Ports:
//   clock, resetn  - clock, synchronous active-low reset (x=y=0)
//   clear          - return to pixel (0,0)
//   advance        - step to the next pixel in raster order
//   x, y           - current pixel coordinate
//   last           - current pixel is (SCREEN_W-1, SCREEN_H-1)
// ---------------------------------------------------------------------------
module raster_counter
  import frame_sequencer_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = X_COORD_WIDTH,
  parameter int YW       = Y_COORD_WIDTH
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
// Initiator side of the datapath start/finished handshake. Walks the whole
// framebuffer in raster order issuing one instruction per pixel: a CLEAR pass
// (DRAW with write-enable and a latched colour) or a REFRESH pass (DISPLAY).
// Optional build macro: FRAME_SEQUENCER_PERF_COUNT_EN adds frame_cycles, the
// number of busy cycles taken by the most recently completed pass.
// Ports:
//   clock, resetn  - clock, synchronous active-low reset
//   clear_req      - one-cycle request for a CLEAR pass
//   clear_colour   - CLEAR colour, sampled when the pass starts
//   refresh_req    - one-cycle request for a REFRESH pass
//   finished       - datapath idle flag (1 = ready)
//   start          - one-cycle instruction strobe
//   instruction    - instruction word, valid while start=1, else 0
//   busy           - a pass is active
//   frame_done     - one-cycle pulse after the last pixel of a pass
//   frame_cycles   - (macro only) busy-cycle count of the last pass
// ---------------------------------------------------------------------------
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         clear_req,
  input  logic [COLOUR_WIDTH-1:0]      clear_colour,
  input  logic                         refresh_req,
  input  logic                         finished,
  output logic                         start,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         busy,
  output logic                         frame_done
`ifdef FRAME_SEQUENCER_PERF_COUNT_EN
  ,
  output logic [23:0]                  frame_cycles
`endif
);

  seq_state_t                state_q, state_d;
  seq_mode_t                 mode_q, pass_mode;
  logic [COLOUR_WIDTH-1:0]   colour_q;
  logic                      pend_clear_q, pend_refresh_q;
  logic                      frame_done_q;
  logic                      pass_begin, pass_end, cnt_adv;
  logic [X_COORD_WIDTH-1:0]  x;
  logic [Y_COORD_WIDTH-1:0]  y;
  logic                      last;

  raster_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XW       (X_COORD_WIDTH),
    .YW       (Y_COORD_WIDTH)
  ) u_raster (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (pass_begin),
    .advance (cnt_adv),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_comb begin
    state_d     = state_q;
    pass_mode   = mode_q;
    pass_begin  = 1'b0;
    pass_end    = 1'b0;
    cnt_adv     = 1'b0;
    start       = 1'b0;
    instruction = '0;
    case (state_q)
      ST_IDLE: begin
        if (pend_clear_q) begin
          pass_begin = 1'b1;
          pass_mode  = MODE_CLEAR;
          state_d    = ST_ISSUE;
        end else if (pend_refresh_q) begin
          pass_begin = 1'b1;
          pass_mode  = MODE_REFRESH;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // start is gated by finished directly so nothing is ever issued to a
        // datapath that is busy, even one grabbed by the external arbiter.
        if (finished) begin
          start   = 1'b1;
          state_d = ST_ACK;
          if (mode_q == MODE_CLEAR)
            instruction = pack_instruction(OPCODE_DRAW, x, y, colour_q, 1'b1);
          else
            instruction = pack_instruction(OPCODE_DISPLAY, x, y, '0, 1'b0);
        end
      end
      ST_ACK: begin
        // finished is still the stale idle flag on the issue edge; wait for
        // it to drop before looking for completion.
        if (!finished) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (finished) begin
          if (last) begin
            pass_end = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending flags are consumed when their pass starts, so a same-mode request
  // arriving mid-pass re-arms the flag and yields one fresh pass afterwards.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pend_clear_q   <= 1'b0;
      pend_refresh_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_done_q   <= pass_end;
      pend_clear_q   <= clear_req |
                        (pend_clear_q & ~(pass_begin && pass_mode == MODE_CLEAR));
      pend_refresh_q <= refresh_req |
                        (pend_refresh_q & ~(pass_begin && pass_mode == MODE_REFRESH));
    end
  end

  // Mode and colour are only observed once a pass has started, so they
  // carry no reset.
  always_ff @(posedge clock) begin
    if (pass_begin) begin
      mode_q <= pass_mode;
      if (pass_mode == MODE_CLEAR) colour_q <= clear_colour;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

`ifdef FRAME_SEQUENCER_PERF_COUNT_EN
  logic [23:0] cyc_cnt_q;
  logic [23:0] frame_cycles_q;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (&v) ? v : v + 24'd1;
  endfunction

  // The load on pass_end includes the final busy cycle, so frame_cycles is
  // already valid while frame_done is high.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cyc_cnt_q      <= '0;
      frame_cycles_q <= '0;
    end else begin
      if (pass_begin)
        cyc_cnt_q <= '0;
      else if (busy)
        cyc_cnt_q <= sat_inc(cyc_cnt_q);
      if (pass_end)
        frame_cycles_q <= sat_inc(cyc_cnt_q);
    end
  end

  assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
  logic        refresh_req = 1'b0;
  logic        finished;
  logic        start;
  logic [31:0] instruction;
  logic        busy;
  logic        frame_done;
`ifdef FRAME_SEQUENCER_PERF_COUNT_EN
  logic [23:0] frame_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // datapath BFM
  int   bfm_cnt = 0;
  logic ext_busy = 1'b0;
  bit   rand_lat = 1'b0;

  // monitor state
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int fd_cnt = 0;
  int busy_cyc = 0;
  int viol_start = 0;
  int viol_fd = 0;
  int idle_run = 0;
  int last_gap = 0;

  frame_sequencer #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .refresh_req  (refresh_req),
    .finished     (finished),
    .start        (start),
    .instruction  (instruction),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef FRAME_SEQUENCER_PERF_COUNT_EN
    ,
    .frame_cycles (frame_cycles)
`endif
  );

  always #5 clock = ~clock;

  assign finished = (bfm_cnt == 0) && !ext_busy;

  always @(posedge clock) begin
    if (bfm_cnt > 0) bfm_cnt <= bfm_cnt - 1;
    else if (start) bfm_cnt <= rand_lat ? int'($urandom_range(4, 1)) : 2;
  end

  always @(negedge clock) begin
    if (resetn) begin
      if (start) begin
        got_q.push_back(instruction);
        if (!finished) viol_start++;
      end
      if (frame_done) begin
        fd_cnt++;
        if (busy) viol_fd++;
      end
      if (busy) begin
        busy_cyc++;
        if (idle_run > 0) last_gap = idle_run;
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: one pass visits every pixel x-inner, y-outer.
  function automatic void model_pass(input bit is_clear, input int colour);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        if (is_clear)
          exp_q.push_back(32'((1 << 22) + (colour << 19) + (yy << 12) + (xx << 4)) + 32'(OPCODE_DRAW));
        else
          exp_q.push_back(32'((yy << 12) + (xx << 4)) + 32'(OPCODE_DISPLAY));
  endfunction

  task automatic pulse_req(input bit c, input bit r, input logic [2:0] col);
    @(negedge clock);
    clear_req = c; refresh_req = r; clear_colour = col;
    @(negedge clock);
    clear_req = 1'b0; refresh_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (fd_cnt < target && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_timeout"}, 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    int n;
    logic [2:0] col;
    logic [31:0] first_w;

    // reset
    repeat (3) @(negedge clock);
    check("rst_start", 32'(start), 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // CLEAR with colour 5
    base = fd_cnt;
    model_pass(1'b1, 5);
    pulse_req(1'b1, 1'b0, 3'b101);
    wait_frames(base + 1, "clear");
    @(negedge clock);
    check("clear_busy_after", 32'(busy), 32'd0);
    repeat (5) @(negedge clock);
    check("clear_fd_once", 32'(fd_cnt), 32'(base + 1));
    compare_words("clear");

    // REFRESH
    base = fd_cnt;
    model_pass(1'b0, 0);
    pulse_req(1'b0, 1'b1, 3'b000);
    wait_frames(base + 1, "refresh");
    repeat (5) @(negedge clock);
    compare_words("refresh");

    // simultaneous requests: CLEAR then REFRESH, one idle cycle between
    base = fd_cnt;
    col = 3'($urandom_range(7, 0));
    model_pass(1'b1, int'(col));
    model_pass(1'b0, 0);
    pulse_req(1'b1, 1'b1, col);
    wait_frames(base + 2, "both");
    check("both_gap", 32'(last_gap), 32'd1);
    repeat (5) @(negedge clock);
    check("both_fd", 32'(fd_cnt), 32'(base + 2));
    compare_words("both");

    // three REFRESH requests during a REFRESH pass coalesce into one more pass
    base = fd_cnt;
    model_pass(1'b0, 0);
    model_pass(1'b0, 0);
    pulse_req(1'b0, 1'b1, 3'b000);
    n = 0;
    while (got_q.size() < 3 && n < 500) begin @(negedge clock); n++; end
    for (int k = 0; k < 3; k++) begin
      pulse_req(1'b0, 1'b1, 3'b000);
      @(negedge clock);
    end
    wait_frames(base + 2, "coalesce");
    repeat (60) @(negedge clock);
    check("coalesce_fd", 32'(fd_cnt), 32'(base + 2));
    check("coalesce_idle", 32'(busy), 32'd0);
    compare_words("coalesce");

    // reset mid-pass
    base = fd_cnt;
    pulse_req(1'b0, 1'b1, 3'b000);
    n = 0;
    while (got_q.size() < 5 && n < 500) begin @(negedge clock); n++; end
    check("midrst_reached5", 32'(got_q.size() >= 5), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_fd", 32'(frame_done), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    check("midrst_no_fd", 32'(fd_cnt), 32'(base));
    check("midrst_idle", 32'(busy), 32'd0);
    got_q.delete();
    model_pass(1'b0, 0);
    pulse_req(1'b0, 1'b1, 3'b000);
    wait_frames(base + 1, "restart");
    repeat (5) @(negedge clock);
    compare_words("restart");

    // datapath externally busy for 10 cycles before the first instruction
    base = fd_cnt;
    @(negedge clock);
    ext_busy = 1'b1;
    n = busy_cyc;
    model_pass(1'b0, 0);
    first_w = exp_q[0];
    pulse_req(1'b0, 1'b1, 3'b000);
    repeat (10) @(negedge clock);
    check("hold_no_start", 32'(got_q.size()), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1 ext_busy = 1'b0;
    #1;
    check("hold_first_start", 32'(start), 32'd1);
    check("hold_first_word", instruction, first_w);
    wait_frames(base + 1, "hold");
`ifdef FRAME_SEQUENCER_PERF_COUNT_EN
    check("perf_cycles", 32'(frame_cycles), 32'(busy_cyc - n));
`endif
    repeat (5) @(negedge clock);
    compare_words("hold");

    // randomized requests and datapath latency
    rand_lat = 1'b1;
    for (int it = 0; it < 4; it++) begin
      int sel;
      base = fd_cnt;
      sel = int'($urandom_range(2, 0));
      col = 3'($urandom_range(7, 0));
      if (sel != 1) model_pass(1'b1, int'(col));
      if (sel != 0) model_pass(1'b0, 0);
      pulse_req(sel != 1, sel != 0, col);
      wait_frames(base + ((sel == 2) ? 2 : 1), $sformatf("rand%0d", it));
      repeat (8) @(negedge clock);
      compare_words($sformatf("rand%0d", it));
    end

    check("start_while_not_finished", 32'(viol_start), 32'd0);
    check("frame_done_while_busy", 32'(viol_fd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
